// File: rtl/mp5_pkg.sv
// Shared types for the MP5 stage ingress scheduler:
// packet format, phantom-map entry and request class.
package mp5_pkg;

    localparam int NUM_PIPELINES_DEF = 2;
    localparam int FIFO_SIZE_DEF     = 8;
    localparam int MAP_DEPTH_DEF     = 8;

    localparam int ID_W       = 16;
    localparam int DATA_W     = 32;
    // Map fields are sized for the largest legal configuration.
    localparam int MAP_FIFO_W = 4;
    localparam int MAP_ADDR_W = 8;

    typedef struct packed {
        logic              is_phantom;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } packet_t;

    typedef struct packed {
        logic                  valid;
        logic [ID_W-1:0]       id;
        logic [MAP_FIFO_W-1:0] fifo;
        logic [MAP_ADDR_W-1:0] addr;
    } map_entry_t;

    typedef enum logic [1:0] {
        CLS_MISS    = 2'd0,
        CLS_PHANTOM = 2'd1,
        CLS_HIT     = 2'd2
    } cls_e;

endpackage

// File: rtl/mp5_addr_map.sv
// Phantom-id address map: small CAM of {id, fifo, addr} entries.
// Ports: lk_* per-requester lookup (port j looks in FIFO j),
// free_* lowest free slot, inv_* per-FIFO pop address,
// stale_o entries evicted by a pop, wr_* write, fr_* free.
module mp5_addr_map
    import mp5_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NLK   = 2,
    parameter int AW    = 3,
    localparam int IW   = $clog2(DEPTH),
    localparam int FW   = $clog2(NLK)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NLK-1:0][ID_W-1:0] lk_id_i,
    output logic [NLK-1:0]           lk_hit_o,
    output logic [NLK-1:0][IW-1:0]   lk_idx_o,
    output logic [NLK-1:0][AW-1:0]   lk_addr_o,
    output logic [NLK-1:0]           id_hit_o,
    output logic [NLK-1:0][IW-1:0]   id_idx_o,
    output logic                     free_ok_o,
    output logic [IW-1:0]            free_idx_o,
    input  logic [NLK-1:0]           inv_vld_i,
    input  logic [NLK-1:0][AW-1:0]   inv_addr_i,
    output logic [DEPTH-1:0]         stale_o,
    input  logic                     wr_en_i,
    input  logic [IW-1:0]            wr_idx_i,
    input  logic [ID_W-1:0]          wr_id_i,
    input  logic [FW-1:0]            wr_fifo_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic                     fr_en_i,
    input  logic [IW-1:0]            fr_idx_i
);

    map_entry_t [DEPTH-1:0] ent_q;
    map_entry_t [DEPTH-1:0] ent_d;

    // An entry whose address is the head being popped is stale.
    always_comb begin
        stale_o = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int f = 0; f < NLK; f++) begin
                if (ent_q[e].valid &&
                    ent_q[e].fifo == MAP_FIFO_W'(f) &&
                    inv_vld_i[f] &&
                    ent_q[e].addr == MAP_ADDR_W'(inv_addr_i[f])) begin
                    stale_o[e] = 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest index wins.
    always_comb begin
        lk_hit_o  = '0;
        lk_idx_o  = '0;
        lk_addr_o = '0;
        id_hit_o  = '0;
        id_idx_o  = '0;
        for (int j = 0; j < NLK; j++) begin
            for (int e = DEPTH-1; e >= 0; e--) begin
                if (ent_q[e].valid && ent_q[e].id == lk_id_i[j]) begin
                    id_hit_o[j] = 1'b1;
                    id_idx_o[j] = IW'(e);
                    if (ent_q[e].fifo == MAP_FIFO_W'(j) &&
                        !stale_o[e]) begin
                        lk_hit_o[j]  = 1'b1;
                        lk_idx_o[j]  = IW'(e);
                        lk_addr_o[j] = ent_q[e].addr[AW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        free_ok_o  = 1'b0;
        free_idx_o = '0;
        for (int e = DEPTH-1; e >= 0; e--) begin
            if (!ent_q[e].valid) begin
                free_ok_o  = 1'b1;
                free_idx_o = IW'(e);
            end
        end
    end

    // A write to an entry evicted in the same cycle wins.
    always_comb begin
        ent_d = ent_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (stale_o[e]) ent_d[e].valid = 1'b0;
        end
        if (fr_en_i) ent_d[fr_idx_i].valid = 1'b0;
        if (wr_en_i) begin
            ent_d[wr_idx_i] = '{
                valid: 1'b1,
                id:    wr_id_i,
                fifo:  MAP_FIFO_W'(wr_fifo_i),
                addr:  MAP_ADDR_W'(wr_addr_i)
            };
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ent_q <= '0;
        else      ent_q <= ent_d;
    end

endmodule

// File: rtl/mp5_ingress_sched.sv
// Ingress scheduler for one MP5 stage: RR arbitration, FIFO
// pointer/credit mirrors and phantom-id map; emits one push or
// insert per transfer one cycle later.
// Ports: in_valid/in_pkt/in_ready requesters, st_* stage command,
// st_pop stage pops, stat_* event counters.
// Counters exist only when MP5_SCHED_STATS_EN is defined.
module mp5_ingress_sched
    import mp5_pkg::*;
#(
    parameter int NUM_PIPELINES = NUM_PIPELINES_DEF,
    parameter int FIFO_SIZE     = FIFO_SIZE_DEF,
    parameter int MAP_DEPTH     = MAP_DEPTH_DEF,
    localparam int PW = $clog2(NUM_PIPELINES),
    localparam int AW = $clog2(FIFO_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PIPELINES-1:0]          in_valid,
    input  packet_t [NUM_PIPELINES-1:0]       in_pkt,
    output logic [NUM_PIPELINES-1:0]          in_ready,
    output logic                              st_push,
    output logic                              st_insert,
    output logic [PW-1:0]                     st_fifo_id,
    output logic [AW-1:0]                     st_addr,
    output packet_t                           st_pkt,
    input  logic [NUM_PIPELINES-1:0]          st_pop,
    output logic [31:0]                       stat_push,
    output logic [31:0]                       stat_insert,
    output logic [31:0]                       stat_stale
);

    localparam int N  = NUM_PIPELINES;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(MAP_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_SIZE);

    logic [N-1:0][CW-1:0] head_q, head_d;
    logic [N-1:0][CW-1:0] tail_q, tail_d;
    logic [N-1:0][CW-1:0] credit_q, credit_d;
    logic [PW-1:0]        rr_q, rr_d;

    logic                 st_push_q, st_push_d;
    logic                 st_ins_q, st_ins_d;
    logic [PW-1:0]        st_fifo_q, st_fifo_d;
    logic [AW-1:0]        st_addr_q, st_addr_d;
    packet_t              st_pkt_q, st_pkt_d;

    logic [N-1:0][ID_W-1:0] lk_id;
    logic [N-1:0]           lk_hit;
    logic [N-1:0][IW-1:0]   lk_idx;
    logic [N-1:0][AW-1:0]   lk_addr;
    logic [N-1:0]           id_hit;
    logic [N-1:0][IW-1:0]   id_idx;
    logic                   free_ok;
    logic [IW-1:0]          free_idx;
    logic [N-1:0][AW-1:0]   inv_addr;
    logic [MAP_DEPTH-1:0]   stale_vec;
    logic                   wr_en;
    logic [IW-1:0]          wr_idx;
    logic                   fr_en;

    logic [N-1:0] pop_eff;
    logic [N-1:0] elig;
    cls_e         cls [N];
    logic         any;
    logic [PW-1:0] gidx;
    logic         xfer;
    logic         do_push;
    logic         do_ins;

    // Pops of an empty FIFO are protocol errors and are dropped.
    always_comb begin
        for (int f = 0; f < N; f++) begin
            pop_eff[f]  = st_pop[f] && (credit_q[f] != FULL);
            inv_addr[f] = head_q[f][AW-1:0];
            lk_id[f]    = in_pkt[f].id;
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            cls[i] = CLS_MISS;
            unique case (1'b1)
                in_pkt[i].is_phantom: begin
                    cls[i]  = CLS_PHANTOM;
                    elig[i] = (credit_q[i] != '0) &&
                              (free_ok || id_hit[i]);
                end
                !in_pkt[i].is_phantom && lk_hit[i]: begin
                    cls[i]  = CLS_HIT;
                    elig[i] = 1'b1;
                end
                !in_pkt[i].is_phantom && !lk_hit[i]: begin
                    cls[i]  = CLS_MISS;
                    elig[i] = (credit_q[i] != '0);
                end
                default: begin
                    cls[i]  = CLS_MISS;
                    elig[i] = 1'b0;
                end
            endcase
            elig[i] = elig[i] && in_valid[i];
        end
    end

    // First eligible at or after rr_q; descending scan keeps
    // the closest one.
    always_comb begin
        logic [PW-1:0] idx;
        any  = 1'b0;
        gidx = '0;
        for (int k = N-1; k >= 0; k--) begin
            idx = rr_q + PW'(k);
            if (elig[idx]) begin
                any  = 1'b1;
                gidx = idx;
            end
        end
        in_ready = '0;
        if (rst && any) in_ready[gidx] = 1'b1;
    end

    always_comb begin
        xfer    = |in_ready;
        do_ins  = xfer && (cls[gidx] == CLS_HIT);
        do_push = xfer && (cls[gidx] != CLS_HIT);
        wr_en   = xfer && (cls[gidx] == CLS_PHANTOM);
        wr_idx  = id_hit[gidx] ? id_idx[gidx] : free_idx;
        fr_en   = do_ins;

        st_push_d = do_push;
        st_ins_d  = do_ins;
        st_fifo_d = st_fifo_q;
        st_addr_d = st_addr_q;
        st_pkt_d  = st_pkt_q;
        if (xfer) begin
            st_fifo_d = gidx;
            st_addr_d = do_ins ? lk_addr[gidx]
                               : tail_q[gidx][AW-1:0];
            st_pkt_d  = in_pkt[gidx];
        end

        rr_d = xfer ? gidx + 1'b1 : rr_q;

        for (int f = 0; f < N; f++) begin
            logic pf;
            pf          = do_push && (gidx == PW'(f));
            tail_d[f]   = tail_q[f] + CW'(pf);
            head_d[f]   = head_q[f] + CW'(pop_eff[f]);
            credit_d[f] = credit_q[f] - CW'(pf)
                        + CW'(pop_eff[f]);
        end
    end

    mp5_addr_map #(
        .DEPTH (MAP_DEPTH),
        .NLK   (N),
        .AW    (AW)
    ) u_map (
        .clk        (clk),
        .rst        (rst),
        .lk_id_i    (lk_id),
        .lk_hit_o   (lk_hit),
        .lk_idx_o   (lk_idx),
        .lk_addr_o  (lk_addr),
        .id_hit_o   (id_hit),
        .id_idx_o   (id_idx),
        .free_ok_o  (free_ok),
        .free_idx_o (free_idx),
        .inv_vld_i  (pop_eff),
        .inv_addr_i (inv_addr),
        .stale_o    (stale_vec),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_id_i    (in_pkt[gidx].id),
        .wr_fifo_i  (gidx),
        .wr_addr_i  (tail_q[gidx][AW-1:0]),
        .fr_en_i    (fr_en),
        .fr_idx_i   (lk_idx[gidx])
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            for (int f = 0; f < N; f++) credit_q[f] <= FULL;
            rr_q      <= '0;
            st_push_q <= 1'b0;
            st_ins_q  <= 1'b0;
            st_fifo_q <= '0;
            st_addr_q <= '0;
            st_pkt_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            credit_q  <= credit_d;
            rr_q      <= rr_d;
            st_push_q <= st_push_d;
            st_ins_q  <= st_ins_d;
            st_fifo_q <= st_fifo_d;
            st_addr_q <= st_addr_d;
            st_pkt_q  <= st_pkt_d;
        end
    end

    assign st_push    = st_push_q;
    assign st_insert  = st_ins_q;
    assign st_fifo_id = st_fifo_q;
    assign st_addr    = st_addr_q;
    assign st_pkt     = st_pkt_q;

`ifdef MP5_SCHED_STATS_EN
    logic [31:0] sp_q, si_q, ss_q;
    logic [31:0] stale_n;

    always_comb begin
        stale_n = '0;
        for (int e = 0; e < MAP_DEPTH; e++) begin
            stale_n = stale_n + 32'(stale_vec[e]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
            si_q <= '0;
            ss_q <= '0;
        end else begin
            sp_q <= sp_q + 32'(do_push);
            si_q <= si_q + 32'(do_ins);
            ss_q <= ss_q + stale_n;
        end
    end

    assign stat_push   = sp_q;
    assign stat_insert = si_q;
    assign stat_stale  = ss_q;
`else
    logic unused_stale;
    assign unused_stale = ^stale_vec;
    assign stat_push    = '0;
    assign stat_insert  = '0;
    assign stat_stale   = '0;
`endif

    for (genvar f = 0; f < N; f++) begin : g_chk
        a_pop_empty: assert property (
            @(posedge clk) disable iff (!rst)
            !(st_pop[f] && credit_q[f] == FULL));
    end

    a_cmd_excl: assert property (
        @(posedge clk) disable iff (!rst)
        !(st_push_q && st_ins_q));

endmodule

// File: tb/tb_mp5_ingress_sched.sv
// Bench for mp5_ingress_sched: queue/assoc-array model of the
// stage FIFOs and phantom map, scoreboard on st_push/st_insert.
module tb_mp5_ingress_sched;
    import mp5_pkg::*;

    localparam int N  = 2;
    localparam int FS = 8;
    localparam int MD = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    packet_t [N-1:0] in_pkt;
    logic [N-1:0]    in_ready;
    logic            st_push;
    logic            st_insert;
    logic [0:0]      st_fifo_id;
    logic [2:0]      st_addr;
    packet_t         st_pkt;
    logic [N-1:0]    st_pop;
    logic [31:0]     stat_push;
    logic [31:0]     stat_insert;
    logic [31:0]     stat_stale;

    mp5_ingress_sched #(
        .NUM_PIPELINES (N),
        .FIFO_SIZE     (FS),
        .MAP_DEPTH     (MD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_pkt      (in_pkt),
        .in_ready    (in_ready),
        .st_push     (st_push),
        .st_insert   (st_insert),
        .st_fifo_id  (st_fifo_id),
        .st_addr     (st_addr),
        .st_pkt      (st_pkt),
        .st_pop      (st_pop),
        .stat_push   (stat_push),
        .stat_insert (stat_insert),
        .stat_stale  (stat_stale)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: FIFO occupancy/pointers and id -> slot map.
    int occ [N];
    int hd  [N];
    int tl  [N];
    int rr;
    int m_fifo [int];
    int m_addr [int];
    int n_push, n_ins, n_stale;

    typedef struct {
        bit      ins;
        int      fifo;
        int      addr;
        packet_t pkt;
        int      due;
    } exp_t;
    exp_t sbq [$];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic packet_t mk(input bit ph, input int id);
        packet_t p;
        p.is_phantom = ph;
        p.id         = 16'(id);
        p.data       = $urandom();
        return p;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < N; f++) begin
            occ[f] = 0;
            hd[f]  = 0;
            tl[f]  = 0;
        end
        rr = 0;
        m_fifo.delete();
        m_addr.delete();
        n_push  = 0;
        n_ins   = 0;
        n_stale = 0;
        sbq.delete();
    endtask

    function automatic bit m_hit(input int i, input packet_t p,
                                 input logic [N-1:0] pop);
        int id = int'(p.id);
        if (!m_fifo.exists(id)) return 0;
        if (m_fifo[id] != i) return 0;
        if (pop[i] && (hd[i] % FS) == m_addr[id]) return 0;
        return 1;
    endfunction

    function automatic bit m_elig(input int i, input logic [N-1:0] v,
                                  input packet_t [N-1:0] p,
                                  input logic [N-1:0] pop);
        if (!v[i]) return 0;
        if (p[i].is_phantom)
            return occ[i] < FS &&
                   (m_fifo.num() < MD || m_fifo.exists(int'(p[i].id)));
        return m_hit(i, p[i], pop) || occ[i] < FS;
    endfunction

    // Called just after a rising edge; returns just after the next.
    task automatic step(input logic [N-1:0] v, input packet_t [N-1:0] p,
                        input logic [N-1:0] pop);
        logic [N-1:0] popm, exp_rdy;
        int g, id;
        bit hit;
        exp_t e;
        int stale_ids [$];
        for (int f = 0; f < N; f++) popm[f] = pop[f] && occ[f] > 0;
        in_valid = v;
        in_pkt   = p;
        st_pop   = popm;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i = (rr + k) % N;
            if (g < 0 && m_elig(i, v, p, popm)) g = i;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
`ifdef MP5_SCHED_STATS_EN
        chk("stat_push", 64'(stat_push), 64'(n_push));
        chk("stat_insert", 64'(stat_insert), 64'(n_ins));
        chk("stat_stale", 64'(stat_stale), 64'(n_stale));
`else
        chk("stat_push", 64'(stat_push), 64'd0);
        chk("stat_stale", 64'(stat_stale), 64'd0);
`endif
        hit = (g >= 0) && !p[g].is_phantom && m_hit(g, p[g], popm);
        for (int f = 0; f < N; f++) begin
            if (popm[f]) begin
                foreach (m_fifo[k])
                    if (m_fifo[k] == f && m_addr[k] == hd[f] % FS)
                        stale_ids.push_back(k);
                hd[f]++;
                occ[f]--;
            end
        end
        foreach (stale_ids[k]) begin
            m_fifo.delete(stale_ids[k]);
            m_addr.delete(stale_ids[k]);
            n_stale++;
        end
        if (g >= 0) begin
            id     = int'(p[g].id);
            e.fifo = g;
            e.pkt  = p[g];
            e.due  = cyc + 1;
            if (hit) begin
                e.ins  = 1;
                e.addr = m_addr[id];
                m_fifo.delete(id);
                m_addr.delete(id);
                n_ins++;
            end else begin
                e.ins  = 0;
                e.addr = tl[g] % FS;
                if (p[g].is_phantom) begin
                    m_fifo[id] = g;
                    m_addr[id] = tl[g] % FS;
                end
                tl[g]++;
                occ[g]++;
                n_push++;
            end
            sbq.push_back(e);
            rr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        packet_t [N-1:0] p;
        p = '0;
        for (int k = 0; k < 40; k++) begin
            if (occ[0] == 0 && occ[1] == 0) break;
            step(2'b00, p, 2'b11);
        end
    endtask

    // Monitor: every command pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (run && rst === 1'b1) begin
            if (st_push && st_insert)
                chk("push_insert_excl", 64'd1, 64'd0);
            if (st_push || st_insert) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_cmd", 64'(st_push), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("cmd_cycle", 64'(cyc), 64'(e.due));
                    chk("cmd_insert", 64'(st_insert), 64'(e.ins));
                    chk("cmd_fifo", 64'(st_fifo_id), 64'(e.fifo));
                    if (e.ins) chk("cmd_addr", 64'(st_addr), 64'(e.addr));
                    chk("cmd_pkt", 64'(st_pkt), 64'(e.pkt));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("missing_cmd", 64'd0, 64'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        packet_t [N-1:0] p;
        rst      = 1'b0;
        in_valid = '0;
        in_pkt   = '0;
        st_pop   = '0;
        p        = '0;
        model_reset();
        repeat (2) @(posedge clk);
        in_valid = 2'b11;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_st_push", 64'(st_push), 64'd0);
        chk("rst_st_insert", 64'(st_insert), 64'd0);
        chk("rst_st_fifo_id", 64'(st_fifo_id), 64'd0);
        chk("rst_st_addr", 64'(st_addr), 64'd0);
        chk("rst_st_pkt", 64'(st_pkt), 64'd0);
        chk("rst_stat_stale", 64'(stat_stale), 64'd0);
        in_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1;

        // Phantom 5 then its real packet overwrites in place.
        p[0] = mk(1, 5);
        step(2'b01, p, 2'b00);
        p[0] = mk(0, 5);
        step(2'b01, p, 2'b00);

        // Two busy requesters alternate.
        for (int k = 0; k < 4; k++) begin
            p[0] = mk(0, 100);
            p[1] = mk(0, 101);
            step(2'b11, p, 2'b00);
        end

        // Fill FIFO 1 until credit runs out, then free one slot.
        for (int k = 0; k < 10; k++) begin
            p[1] = mk(0, 200 + k);
            step(2'b10, p, 2'b00);
        end
        step(2'b10, p, 2'b10);
        step(2'b10, p, 2'b00);
        drain();

        // Stale eviction of phantom 9, then real 9 is pushed.
        p[0] = mk(1, 9);
        step(2'b01, p, 2'b00);
        step(2'b00, p, 2'b01);
        p[0] = mk(0, 9);
        step(2'b01, p, 2'b00);
        drain();

        // Fill the map, block a new phantom, real still flows.
        for (int k = 0; k < 8; k++) begin
            p[k % 2] = mk(1, 20 + k);
            step((k % 2) ? 2'b10 : 2'b01, p, 2'b00);
        end
        p[0] = mk(1, 30);
        step(2'b01, p, 2'b00);
        p[1] = mk(0, 40);
        step(2'b11, p, 2'b00);
        p[0] = mk(0, 20);
        step(2'b01, p, 2'b00);
        p[0] = mk(1, 30);
        step(2'b01, p, 2'b00);
        drain();

        // Random traffic over a small id pool.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                p[i] = mk(1'($urandom_range(0, 1)),
                          $urandom_range(1, 12));
            step(N'($urandom()), p, N'($urandom()));
        end
        drain();

        // Reset with a command in flight.
        p[0] = mk(0, 77);
        step(2'b01, p, 2'b00);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_push", 64'(st_push), 64'd0);
        chk("rst_mid_insert", 64'(st_insert), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd0);
        chk("rst_mid_stat", 64'(stat_push), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full credit after reset: eight accepted, ninth held.
        for (int k = 0; k < 9; k++) begin
            p[0] = mk(0, 300 + k);
            step(2'b01, p, 2'b00);
        end
        p = '0;
        step(2'b00, p, 2'b00);
        step(2'b00, p, 2'b00);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
